out_channel_reader: RTL and testbench

//  Consumer end of a test program's out channel: accepts words over valid/ready and stores them in an

---
 rtl/out_channel_reader.sv | 143 ++++++++++++++
 tb/tb_out_channel_reader.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/out_channel_reader.sv
// Consumer end of a test program's out channel: collects words into a circular
// buffer, then compares the buffer against Expected and reports finished/success.
module out_channel_reader #(
    parameter int MemoryElementWidth = 12,
    parameter int NOut = 1,
    parameter int NExpected = 1,
    parameter logic [MemoryElementWidth*NExpected-1:0] Expected = 12'd2,
    parameter int MaxSteps = 64
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          out_valid,
    input  logic [MemoryElementWidth-1:0] out_data,
    output logic                          out_ready,
    input  logic                          program_done,
    output logic [15:0]                   words_seen,
    output logic [15:0]                   fail_index,
    output logic                          finished,
    output logic                          success
);

    localparam int W    = MemoryElementWidth;
    localparam int PosW = (NOut > 1) ? $clog2(NOut) : 1;

    typedef enum logic [1:0] {IDLE, COLLECT, COMPARE, DONE} state_e;

    state_e          state_q, state_d;
    logic [W-1:0]    mem_q [NOut];
    logic [W-1:0]    mem_d [NOut];
    logic [PosW-1:0] pos_q, pos_d;
    logic [15:0]     words_q, words_d;
    logic [15:0]     step_q, step_d;
    logic [15:0]     idx_q, idx_d;
    logic [15:0]     fail_q, fail_d;
    logic            timeout_q, timeout_d;
    logic            finished_q, finished_d;
    logic            success_q, success_d;

    logic [W-1:0]    exp_arr [NOut];
    logic [PosW-1:0] cmp_idx;

    // Expected unpacked into slot order; slots past NExpected are never compared.
    for (genvar g = 0; g < NOut; g++) begin : g_exp
        if (g < NExpected) begin : g_used
            assign exp_arr[g] = Expected[g*W +: W];
        end else begin : g_pad
            assign exp_arr[g] = '0;
        end
    end

    assign cmp_idx = idx_q[PosW-1:0];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            for (int unsigned i = 0; i < NOut; i++) mem_q[i] <= '0;
            pos_q      <= '0;
            words_q    <= '0;
            step_q     <= '0;
            idx_q      <= '0;
            fail_q     <= '1;
            timeout_q  <= 1'b0;
            finished_q <= 1'b0;
            success_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            mem_q      <= mem_d;
            pos_q      <= pos_d;
            words_q    <= words_d;
            step_q     <= step_d;
            idx_q      <= idx_d;
            fail_q     <= fail_d;
            timeout_q  <= timeout_d;
            finished_q <= finished_d;
            success_q  <= success_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, DONE: if (start) state_d = COLLECT;
            COLLECT:    if (program_done || step_q == 16'(MaxSteps - 1)) state_d = COMPARE;
            COMPARE:    if (idx_q == 16'(NExpected - 1)) state_d = DONE;
            default:    state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_d      = mem_q;
        pos_d      = pos_q;
        words_d    = words_q;
        step_d     = step_q;
        idx_d      = idx_q;
        fail_d     = fail_q;
        timeout_d  = timeout_q;
        finished_d = finished_q;
        success_d  = success_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    for (int unsigned i = 0; i < NOut; i++) mem_d[i] = '0;
                    pos_d      = '0;
                    words_d    = '0;
                    step_d     = '0;
                    idx_d      = '0;
                    fail_d     = '1;
                    timeout_d  = 1'b0;
                    finished_d = 1'b0;
                    success_d  = 1'b0;
                end else if (state_q == DONE) begin
                    finished_d = 1'b1;
                    success_d  = (fail_q == 16'hFFFF) && (words_q >= 16'(NExpected)) && !timeout_q;
                end
            end
            COLLECT: begin
                if (out_valid) begin
                    mem_d[pos_q] = out_data;
                    pos_d        = (pos_q == PosW'(NOut - 1)) ? '0 : pos_q + 1'b1;
                    if (words_q != 16'hFFFF) words_d = words_q + 16'd1;
                end
                step_d = step_q + 16'd1;
                // program_done takes precedence, so a simultaneous timeout is not a failure.
                if (!program_done && step_q == 16'(MaxSteps - 1)) timeout_d = 1'b1;
            end
            COMPARE: begin
                if (mem_q[cmp_idx] != exp_arr[cmp_idx] && fail_q == 16'hFFFF) fail_d = idx_q;
                idx_d = idx_q + 16'd1;
            end
            default: ;
        endcase
    end

    always_comb begin
        out_ready  = (state_q == COLLECT);
        words_seen = words_q;
        fail_index = fail_q;
        finished   = finished_q;
        success    = success_q;
    end

endmodule

// File: tb/tb_out_channel_reader.sv
// Directed vector bench for out_channel_reader: three configurations driven
// independently (default, 3-deep buffer, short timeout).
module tb_out_channel_reader;

    logic        clock = 1'b0;
    logic        reset;
    logic        start_v [3];
    logic        valid_v [3];
    logic        pd_v    [3];
    logic [11:0] data_v  [3];
    logic        ready_v [3];
    logic        fin_v   [3];
    logic        succ_v  [3];
    logic [15:0] ws_v    [3];
    logic [15:0] fi_v    [3];

    int nvec  = 0;
    int nfail = 0;

    always #5 clock = ~clock;

    out_channel_reader u0 (
        .clock(clock), .reset(reset), .start(start_v[0]), .out_valid(valid_v[0]),
        .out_data(data_v[0]), .out_ready(ready_v[0]), .program_done(pd_v[0]),
        .words_seen(ws_v[0]), .fail_index(fi_v[0]), .finished(fin_v[0]), .success(succ_v[0])
    );

    out_channel_reader #(
        .NOut(3), .NExpected(3), .Expected({12'd30, 12'd20, 12'd10})
    ) u1 (
        .clock(clock), .reset(reset), .start(start_v[1]), .out_valid(valid_v[1]),
        .out_data(data_v[1]), .out_ready(ready_v[1]), .program_done(pd_v[1]),
        .words_seen(ws_v[1]), .fail_index(fi_v[1]), .finished(fin_v[1]), .success(succ_v[1])
    );

    out_channel_reader #(
        .MaxSteps(8)
    ) u2 (
        .clock(clock), .reset(reset), .start(start_v[2]), .out_valid(valid_v[2]),
        .out_data(data_v[2]), .out_ready(ready_v[2]), .program_done(pd_v[2]),
        .words_seen(ws_v[2]), .fail_index(fi_v[2]), .finished(fin_v[2]), .success(succ_v[2])
    );

    typedef struct {
        int               k;
        int               n;
        logic [3:0][11:0] w;
        bit               pd_last;
        bit               exp_s;
        logic [15:0]      exp_fi;
        logic [15:0]      exp_ws;
    } vec_t;

    vec_t tbl [11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic run_txn(input int k, input int n, input logic [3:0][11:0] w, input bit pd_last,
                           input bit es, input logic [15:0] efi, input logic [15:0] ews,
                           input string tag);
        int cnt;
        int ne;
        ne = (k == 1) ? 3 : 1;
        @(negedge clock);
        start_v[k] = 1'b1;
        @(negedge clock);
        start_v[k] = 1'b0;
        chk({tag, " ready_after_start"}, 32'(ready_v[k]), 32'd1);
        chk({tag, " finished_cleared"}, 32'(fin_v[k]), 32'd0);
        for (int i = 0; i < n; i++) begin
            valid_v[k] = 1'b1;
            data_v[k]  = w[i];
            if (pd_last && i == n - 1) pd_v[k] = 1'b1;
            @(negedge clock);
        end
        valid_v[k] = 1'b0;
        if (!(pd_last && n > 0)) begin
            pd_v[k] = 1'b1;
            @(negedge clock);
        end
        pd_v[k] = 1'b0;
        cnt = 0;
        while (!fin_v[k] && cnt < 50) begin
            @(negedge clock);
            cnt++;
        end
        chk({tag, " latency"}, 32'(cnt), 32'(ne + 1));
        chk({tag, " success"}, 32'(succ_v[k]), 32'(es));
        chk({tag, " fail_index"}, 32'(fi_v[k]), 32'(efi));
        chk({tag, " words_seen"}, 32'(ws_v[k]), 32'(ews));
        chk({tag, " ready_done"}, 32'(ready_v[k]), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int cnt;
        tbl[0]  = '{0, 1, {36'd0, 12'd2},                    1'b0, 1'b1, 16'hFFFF, 16'd1};
        tbl[1]  = '{0, 1, {36'd0, 12'd3},                    1'b0, 1'b0, 16'd0,    16'd1};
        tbl[2]  = '{0, 0, 48'd0,                             1'b0, 1'b0, 16'd0,    16'd0};
        tbl[3]  = '{0, 2, {24'd0, 12'd2, 12'd3},             1'b1, 1'b1, 16'hFFFF, 16'd2};
        tbl[4]  = '{0, 2, {24'd0, 12'd3, 12'd2},             1'b0, 1'b0, 16'd0,    16'd2};
        tbl[5]  = '{0, 1, {36'd0, 12'h802},                  1'b1, 1'b0, 16'd0,    16'd1};
        tbl[6]  = '{1, 4, {12'd40, 12'd30, 12'd20, 12'd10},  1'b0, 1'b0, 16'd0,    16'd4};
        tbl[7]  = '{1, 3, {12'd0, 12'd30, 12'd20, 12'd10},   1'b1, 1'b1, 16'hFFFF, 16'd3};
        tbl[8]  = '{1, 3, {12'd0, 12'd31, 12'd20, 12'd10},   1'b0, 1'b0, 16'd2,    16'd3};
        tbl[9]  = '{1, 2, {24'd0, 12'd20, 12'd10},           1'b0, 1'b0, 16'd2,    16'd2};
        tbl[10] = '{1, 3, {12'd0, 12'd30, 12'd21, 12'd11},   1'b0, 1'b0, 16'd0,    16'd3};

        for (int k = 0; k < 3; k++) begin
            start_v[k] = 1'b0;
            valid_v[k] = 1'b0;
            pd_v[k]    = 1'b0;
            data_v[k]  = '0;
        end
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;

        chk("reset ready", 32'(ready_v[0]), 32'd0);
        chk("reset finished", 32'(fin_v[0]), 32'd0);
        chk("reset success", 32'(succ_v[0]), 32'd0);
        chk("reset words_seen", 32'(ws_v[0]), 32'd0);
        chk("reset fail_index", 32'(fi_v[0]), 32'hFFFF);

        // Valid while not ready must be ignored.
        valid_v[0] = 1'b1;
        data_v[0]  = 12'd2;
        repeat (2) @(negedge clock);
        valid_v[0] = 1'b0;
        chk("idle valid ignored", 32'(ws_v[0]), 32'd0);

        for (int v = 0; v < 11; v++) begin
            run_txn(tbl[v].k, tbl[v].n, tbl[v].w, tbl[v].pd_last,
                    tbl[v].exp_s, tbl[v].exp_fi, tbl[v].exp_ws, $sformatf("vec%0d", v));
        end

        // Timeout: one good word, no program_done; COLLECT lasts 8 cycles.
        @(negedge clock);
        start_v[2] = 1'b1;
        @(negedge clock);
        start_v[2] = 1'b0;
        chk("timeout ready", 32'(ready_v[2]), 32'd1);
        valid_v[2] = 1'b1;
        data_v[2]  = 12'd2;
        @(negedge clock);
        valid_v[2] = 1'b0;
        cnt = 1;
        while (!fin_v[2] && cnt < 50) begin
            @(negedge clock);
            cnt++;
        end
        chk("timeout latency", 32'(cnt), 32'd10);
        chk("timeout success", 32'(succ_v[2]), 32'd0);
        chk("timeout fail_index", 32'(fi_v[2]), 32'hFFFF);
        chk("timeout words_seen", 32'(ws_v[2]), 32'd1);

        // Asynchronous reset mid-COLLECT with a pending word.
        @(negedge clock);
        start_v[0] = 1'b1;
        @(negedge clock);
        start_v[0] = 1'b0;
        valid_v[0] = 1'b1;
        data_v[0]  = 12'd2;
        @(negedge clock);
        data_v[0] = 12'd3;
        chk("pre-reset words_seen", 32'(ws_v[0]), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("async reset ready", 32'(ready_v[0]), 32'd0);
        chk("async reset words_seen", 32'(ws_v[0]), 32'd0);
        chk("async reset fail_index", 32'(fi_v[0]), 32'hFFFF);
        chk("async reset finished", 32'(fin_v[0]), 32'd0);
        valid_v[0] = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        run_txn(0, 1, {36'd0, 12'd2}, 1'b0, 1'b1, 16'hFFFF, 16'd1, "restart");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
